// File: rtl/mem_access_ctl.sv
// MEM-stage sequencer: data-memory req/ack handshake, pipeline stall, branch resolution, misalign/timeout abort.
// Optional MEM_PERF_CNT_EN adds saturating stall-cycle and completed-access counters on perf_stall/perf_acc.
module mem_access_ctl #(
    parameter int WAIT_MAX = 15,
    parameter int TMO_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        flush,
    output logic        mem_err,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_acc
);

    // state | meaning
    // IDLE  | evaluate EX/MEM; stall one cycle while launching an access
    // BUSY  | request outstanding, waiting for dmem_ack or timeout
    // ERR   | one-cycle abort: flush the faulting instruction
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(WAIT_MAX - 1);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic             req_nxt, we_nxt, err_nxt;
    logic [31:0]      addr_nxt, wdata_nxt;
    logic             acc, misaligned;

    assign acc        = valid & (memread | memwrite);
    assign misaligned = (alu_result[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dmem_req   <= req_nxt;
            dmem_we    <= we_nxt;
            dmem_addr  <= addr_nxt;
            dmem_wdata <= wdata_nxt;
            mem_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = dmem_req;
        we_nxt    = dmem_we;
        addr_nxt  = dmem_addr;
        wdata_nxt = dmem_wdata;
        err_nxt   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_BUSY;
                        req_nxt   = 1'b1;
                        we_nxt    = memwrite;
                        addr_nxt  = alu_result;
                        wdata_nxt = rdata2out;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_BUSY: begin
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    state_nxt = S_IDLE;
                    req_nxt   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERR;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + TMO_W'(1);
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A branch carried with a memory op resolves on the ack cycle, when stall drops.
    assign pcsrc         = valid & branch & zero & ~stall;
    assign flush         = pcsrc | (state == S_ERR);
    assign branch_target = add_result;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [15:0] acc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            acc_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((state == S_BUSY) && dmem_ack && (acc_cnt != '1)) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
        end
    end

    assign perf_stall = stall_cnt;
    assign perf_acc   = acc_cnt;
`else
    assign perf_stall = '0;
    assign perf_acc   = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctl.sv
// Self-checking bench for mem_access_ctl: directed cases plus randomized instructions
// checked against a transaction-level model of stall/request/error cycle counts.
module tb_mem_access_ctl;

    localparam int WAIT_MAX = 15;
    localparam int TMO_W    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, branch, memread, memwrite, zero;
    logic [31:0] add_result, alu_result, rdata2out;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        stall, pcsrc, flush, mem_err;
    logic [31:0] branch_target, perf_stall;
    logic [15:0] perf_acc;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_pstall = 0;
    int exp_pacc   = 0;

    mem_access_ctl #(.WAIT_MAX(WAIT_MAX), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .branch(branch),
        .memread(memread), .memwrite(memwrite), .zero(zero),
        .add_result(add_result), .alu_result(alu_result), .rdata2out(rdata2out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .stall(stall),
        .pcsrc(pcsrc), .branch_target(branch_target), .flush(flush),
        .mem_err(mem_err), .perf_stall(perf_stall), .perf_acc(perf_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one instruction in EX/MEM until it leaves (stall low), acking after n_wait busy cycles.
    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_instr(input string name, input bit v, input bit br, input bit rd,
                             input bit wr, input bit z, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] tgt, input int n_wait);
        int  c_stall = 0, c_req = 0, c_err = 0, c_flush = 0, c_pc = 0, c_bad = 0, k = 0;
        bit  done = 0;
        bit  acc, mis, tmo;
        int  e_stall, e_req, e_err, e_pc;
        logic [31:0] tgt_seen = '0;

        acc = v && (rd || wr);
        mis = acc && (addr[1:0] != 2'b00);
        tmo = acc && !mis && (n_wait >= WAIT_MAX);
        e_stall = !acc ? 0 : mis ? 1 : tmo ? WAIT_MAX + 1 : 1 + n_wait;
        e_req   = (!acc || mis) ? 0 : tmo ? WAIT_MAX : n_wait + 1;
        e_err   = (mis || tmo) ? 1 : 0;
        e_pc    = (v && br && z) ? 1 : 0;

        valid = v; branch = br; memread = rd; memwrite = wr; zero = z;
        alu_result = addr; rdata2out = wd; add_result = tgt;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            dmem_ack = dmem_req && (k == n_wait);
            #1;
            if (dmem_req === 1'b1) begin
                c_req++;
                k++;
                if (dmem_addr !== addr || dmem_wdata !== wd || dmem_we !== wr) c_bad++;
            end
            if (stall === 1'b1)   c_stall++;
            if (mem_err === 1'b1) c_err++;
            if (flush === 1'b1)   c_flush++;
            if (pcsrc === 1'b1)   c_pc++;
            if (stall === 1'b0) begin
                done = 1;
                tgt_seen = branch_target;
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;

        exp_pstall += e_stall;
        if (acc && !mis && !tmo) exp_pacc++;

        chk({name, ".done"},   32'(done),    32'd1);
        chk({name, ".stall"},  32'(c_stall), 32'(e_stall));
        chk({name, ".req"},    32'(c_req),   32'(e_req));
        chk({name, ".err"},    32'(c_err),   32'(e_err));
        chk({name, ".pcsrc"},  32'(c_pc),    32'(e_pc));
        chk({name, ".flush"},  32'(c_flush), 32'((e_pc != 0 || e_err != 0) ? 1 : 0));
        chk({name, ".held"},   32'(c_bad),   32'd0);
        chk({name, ".target"}, tgt_seen,     tgt);
    endtask

    initial begin
        bit          v, br, rd, wr, z;
        int          mode, nw;
        logic [31:0] a, wd, tg;

        rst_n = 1'b0;
        valid = 0; branch = 0; memread = 0; memwrite = 0; zero = 0; dmem_ack = 0;
        add_result = '0; alu_result = '0; rdata2out = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req",   32'(dmem_req),  32'd0);
        chk("rst.we",    32'(dmem_we),   32'd0);
        chk("rst.addr",  dmem_addr,      32'd0);
        chk("rst.wdata", dmem_wdata,     32'd0);
        chk("rst.err",   32'(mem_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr("load_fast",  1, 0, 1, 0, 0, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
        run_instr("store_w3",   1, 0, 0, 1, 0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 3);
        run_instr("load_mis",   1, 0, 1, 0, 0, 32'h0000_0013, 32'h0,         32'h0, 0);
        run_instr("load_tmo",   1, 0, 1, 0, 0, 32'h0000_0030, 32'h0,         32'h0, WAIT_MAX);
        run_instr("load_edge",  1, 0, 1, 0, 0, 32'h0000_0034, 32'h0,         32'h0, WAIT_MAX - 1);
        run_instr("br_taken",   1, 1, 0, 0, 1, 32'h0,         32'h0, 32'h0000_0040, 0);
        run_instr("br_not",     1, 1, 0, 0, 0, 32'h0,         32'h0, 32'h0000_0040, 0);
        run_instr("br_ld",      1, 1, 1, 0, 1, 32'h0000_0044, 32'h0, 32'h0000_0080, 2);
        run_instr("rw_both",    1, 0, 1, 1, 0, 32'h0000_0048, 32'hCAFE_F00D, 32'h0, 1);
        run_instr("invalid",    0, 1, 1, 0, 1, 32'h0000_0013, 32'h0, 32'h0000_0050, 0);

        for (int i = 0; i < 30; i++) begin
            v    = ($urandom_range(0, 5) != 0);
            mode = $urandom_range(0, 3);
            rd   = (mode == 1) || (mode == 3);
            wr   = (mode == 2) || (mode == 3);
            z    = $urandom_range(0, 1) != 0;
            br   = $urandom_range(0, 1) != 0;
            a    = $urandom;
            a[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wd   = $urandom;
            tg   = $urandom;
            nw   = ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, 5);
            if (v && (rd || wr) && (a[1:0] != 2'b00 || nw >= WAIT_MAX)) br = 0;
            run_instr($sformatf("rnd%0d", i), v, br, rd, wr, z, a, wd, tg, nw);
        end

        valid = 0; memread = 0; memwrite = 0; branch = 0;
        @(negedge clk);
        #1;
`ifdef MEM_PERF_CNT_EN
        chk("perf_stall", perf_stall,           32'(exp_pstall));
        chk("perf_acc",   {16'h0, perf_acc},    32'(exp_pacc));
`else
        chk("perf_stall", perf_stall,           32'd0);
        chk("perf_acc",   {16'h0, perf_acc},    32'd0);
`endif

        // Reset asserted during the second BUSY cycle of a load.
        @(negedge clk);
        valid = 1; memread = 1; memwrite = 0; branch = 0; alu_result = 32'h0000_0060;
        dmem_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rstbusy.req_before", 32'(dmem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstbusy.req_after",  32'(dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 0; memread = 0;
        dmem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stray%0d.req", i),   32'(dmem_req), 32'd0);
            chk($sformatf("stray%0d.stall", i), 32'(stall),    32'd0);
            chk($sformatf("stray%0d.err", i),   32'(mem_err),  32'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        run_instr("post_rst", 1, 0, 0, 1, 0, 32'h0000_0070, 32'h0BAD_CAFE, 32'h0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
